mp_drive_sched: RTL
===================

// Module: mp_drive_sched
// PURPOSE
//  Clocked scheduler sharing one click-based micropipeline FIFO input among N requesters.
//  - Round-robin arbitration.
//  - Issues a drive pulse per grant, then waits for the pipeline's free acknowledge.
//  - Counts completed transfers.
//  - Sits between synchronous producer logic and the async FIFO's i_drive/o_free/o_fire_1 ports.
// PARAMETERS
//  N_REQ     4   number of requesters (2..8)
//  DRIVE_W   2   cycles o_drive held high per transfer (1..15)
//  CNT_W     16  width of transfer counter
//  WDOG_W    8   watchdog counter width (used only with MP_WATCHDOG_EN)
// PORTS
//  clk        in   1        system clock
//  rst_n      in   1        async active-low reset
//  i_req      in   N_REQ    level request per requester; held until grant
//  o_gnt      out  N_REQ    one-hot grant; single-cycle pulse when transfer completes
//  o_drive    out  1        drive to micropipeline i_drive
//  i_free     in   1        async free from micropipeline o_free (synchronised internally)
//  i_fire     in   1        async fire from micropipeline o_fire_1 (synchronised internally)
//  o_busy     out  1        high from arbitration until the transfer completes
//  o_cur_id   out  clog2(N) index of the requester currently served
//  o_xfer_cnt out  CNT_W    completed-transfer count, wraps modulo 2^CNT_W
//  o_fire_cnt out  CNT_W    count of synchronised i_fire rising edges, wraps
//  o_err      out  1        sticky watchdog error (0 without MP_WATCHDOG_EN)
// BEHAVIOUR
//  Reset: every output is 0; FSM is in IDLE; RR pointer = 0; both synchronisers cleared.
//  Synchronisers: i_free and i_fire each pass through a 2-flop sync.
//   Edge detect takes a 3rd flop; event = sync & ~prev.
//  FSM:
//   IDLE: if |i_req, go to ARB next cycle; else stay.
//   ARB: pick the first set i_req at or after the RR pointer (circular); latch o_cur_id.
//    o_busy=1; go to DRIVE.
//    If i_req has dropped to 0, return to IDLE without a grant.
//   DRIVE: o_drive=1 for exactly DRIVE_W cycles, then 0; go to WAIT.
//   WAIT: on a free rising-edge event:
//    o_gnt[cur_id] pulses 1 cycle; o_xfer_cnt++; RR pointer = cur_id+1 mod N_REQ.
//    o_busy drops next cycle; go to IDLE.
//  Latency: request to o_drive rise = 2 cycles (IDLE->ARB->DRIVE).
//  Back-to-back: IDLE re-arbitrates the cycle after the grant; no overlapping drives.
//  Simultaneous events: a free edge arriving during DRIVE is remembered (pending flag).
//   WAIT consumes it on its first cycle.
//  Fire counting: independent of the FSM; counts in every state, including IDLE.
//  Counter wrap: 2^CNT_W-1 +1 -> 0 silently.
//  Requests dropped mid-transfer (after ARB) do not abort; the transfer completes and is granted.
//  Reset mid-operation: immediate return to reset state; o_drive drops asynchronously.
//   The pending flag is cleared.
// CONFIGURATION
//  MP_WATCHDOG_EN defined:
//   - WAIT runs a WDOG_W counter.
//   - On reaching all-ones with no free edge: set sticky o_err; return to IDLE without grant or count.
//   - RR pointer still advances past cur_id.
//   - o_err clears only on reset.
//  MP_WATCHDOG_EN undefined: no counter; WAIT waits indefinitely; o_err tied to 0.
// TESTING
//  1. Reset, i_req=4'b0010, free edge 3 cycles after o_drive falls ->
//     o_drive high cycles 2-3; o_gnt=4'b0010 one cycle; o_xfer_cnt=1.
//  2. i_req=4'b1111 held, free returned each time ->
//     grant order 0,1,2,3,0; o_xfer_cnt=5; o_fire_cnt=number of fire edges driven.
//  3. Free edge pulsed during DRIVE ->
//     grant on the first WAIT cycle; exactly one grant; no double count.
//  4. rst_n low mid-DRIVE ->
//     o_drive=0 immediately, outputs 0; after release with i_req=0 the FSM stays IDLE.
//  5. CNT_W=4, 17 transfers -> o_xfer_cnt=1.
//  6. MP_WATCHDOG_EN, WDOG_W=4, free never returns ->
//     o_err=1 after 15 WAIT cycles; no grant; next request served normally.

Source files
------------

// File: rtl/mp_drive_sched_if.sv
// Bus between the micropipeline drive scheduler and its requesters / async FIFO ports.
// master: the scheduler side; slave: the environment (requesters and micropipeline).
interface mp_drive_sched_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] i_req;
  logic [N_REQ-1:0] o_gnt;
  logic             o_drive;
  logic             i_free;
  logic             i_fire;
  logic             o_busy;
  logic [ID_W-1:0]  o_cur_id;
  logic [CNT_W-1:0] o_xfer_cnt;
  logic [CNT_W-1:0] o_fire_cnt;
  logic             o_err;

  modport master (
    input  i_req, i_free, i_fire,
    output o_gnt, o_drive, o_busy, o_cur_id, o_xfer_cnt, o_fire_cnt, o_err
  );

  modport slave (
    output i_req, i_free, i_fire,
    input  o_gnt, o_drive, o_busy, o_cur_id, o_xfer_cnt, o_fire_cnt, o_err
  );
endinterface

// File: rtl/mp_drive_sched.sv
// Round-robin scheduler sharing one click-micropipeline FIFO input among N_REQ requesters.
// Optional macro MP_WATCHDOG_EN adds a WAIT-state watchdog with a sticky error flag.
module mp_drive_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DRIVE_W = 2,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned WDOG_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mp_drive_sched_if.master   bus
);

  localparam int unsigned ID_W   = $clog2(N_REQ);
  localparam int unsigned DCNT_W = 4;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("N_REQ must be 2..8");
  end
  if (DRIVE_W < 1 || DRIVE_W > 15) begin : g_bad_drive_w
    $error("DRIVE_W must be 1..15");
  end
  if (WDOG_W < 1) begin : g_bad_wdog_w
    $error("WDOG_W must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ARB, DRIVE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [2:0]        free_sync_q, fire_sync_q;
  logic              free_ev, fire_ev;
  logic              drive_q, drive_d;
  logic              busy_q, busy_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [ID_W-1:0]   rr_q, rr_d, rr_next;
  logic [CNT_W-1:0]  xfer_q, xfer_d;
  logic [CNT_W-1:0]  fire_cnt_q;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              pend_q, pend_d;
  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  int unsigned       idx;
`ifdef MP_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic              err_q, err_d;
`endif

  // Two-flop synchronisers plus a third flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_sync_q <= '0;
      fire_sync_q <= '0;
    end else begin
      free_sync_q <= {free_sync_q[1:0], bus.i_free};
      fire_sync_q <= {fire_sync_q[1:0], bus.i_fire};
    end
  end

  assign free_ev = free_sync_q[1] & ~free_sync_q[2];
  assign fire_ev = fire_sync_q[1] & ~fire_sync_q[2];
  assign rr_next = (cur_id_q == ID_W'(N_REQ - 1)) ? '0 : cur_id_q + ID_W'(1);

  // First active request at or after the round-robin pointer, circularly
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = k + 32'(rr_q);
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_found && bus.i_req[ID_W'(idx)]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

`ifdef MP_WATCHDOG_EN
  assign wdog_inc = wdog_q + WDOG_W'(1);
`endif

  always_comb begin
    state_d  = state_q;
    drive_d  = 1'b0;
    busy_d   = busy_q;
    gnt_d    = '0;
    cur_id_d = cur_id_q;
    rr_d     = rr_q;
    xfer_d   = xfer_q;
    dcnt_d   = dcnt_q;
    pend_d   = pend_q;
`ifdef MP_WATCHDOG_EN
    wdog_d   = wdog_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        busy_d = |bus.i_req;
        if (|bus.i_req) state_d = ARB;
      end
      ARB: begin
        if (pick_found) begin
          cur_id_d = pick_id;
          busy_d   = 1'b1;
          dcnt_d   = '0;
          drive_d  = 1'b1;
          state_d  = DRIVE;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      DRIVE: begin
        // A free edge arriving while still driving is held for WAIT
        if (free_ev) pend_d = 1'b1;
        if (dcnt_q == DCNT_W'(DRIVE_W - 1)) begin
          state_d = WAIT;
`ifdef MP_WATCHDOG_EN
          wdog_d  = '0;
`endif
        end else begin
          drive_d = 1'b1;
          dcnt_d  = dcnt_q + DCNT_W'(1);
        end
      end
      WAIT: begin
        if (free_ev || pend_q) begin
          gnt_d   = N_REQ'(1) << cur_id_q;
          xfer_d  = xfer_q + CNT_W'(1);
          rr_d    = rr_next;
          pend_d  = 1'b0;
          state_d = IDLE;
        end
`ifdef MP_WATCHDOG_EN
        else if (&wdog_inc) begin
          err_d   = 1'b1;
          rr_d    = rr_next;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_inc;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      drive_q  <= 1'b0;
      busy_q   <= 1'b0;
      gnt_q    <= '0;
      cur_id_q <= '0;
      rr_q     <= '0;
      xfer_q   <= '0;
      dcnt_q   <= '0;
      pend_q   <= 1'b0;
`ifdef MP_WATCHDOG_EN
      wdog_q   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      drive_q  <= drive_d;
      busy_q   <= busy_d;
      gnt_q    <= gnt_d;
      cur_id_q <= cur_id_d;
      rr_q     <= rr_d;
      xfer_q   <= xfer_d;
      dcnt_q   <= dcnt_d;
      pend_q   <= pend_d;
`ifdef MP_WATCHDOG_EN
      wdog_q   <= wdog_d;
      err_q    <= err_d;
`endif
    end
  end

  // Fire edges are counted regardless of scheduler state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fire_cnt_q <= '0;
    else if (fire_ev) fire_cnt_q <= fire_cnt_q + CNT_W'(1);
  end

  assign bus.o_drive    = drive_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_gnt      = gnt_q;
  assign bus.o_cur_id   = cur_id_q;
  assign bus.o_xfer_cnt = xfer_q;
  assign bus.o_fire_cnt = fire_cnt_q;
`ifdef MP_WATCHDOG_EN
  assign bus.o_err      = err_q;
`else
  assign bus.o_err      = 1'b0;
`endif

endmodule
